// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer
//   USB transmit parallel-to-serial stage. Accepts packet words over a
//   valid/ready handshake backed by a one-deep holding register, shifts
//   them out on a bit-rate strobe with bit stuffing and NRZI encoding, then
//   appends EOP (SE0) and a single idle (J) bit.
//
// Ports
//   clk         system clock
//   n_rst       synchronous active-low reset
//   bit_strobe  one-clk pulse per USB bit time; line activity advances on it
//   load_valid  load_data/load_last are valid
//   load_data   word to transmit
//   load_last   this word ends the packet
//   load_ready  holding register empty (accept on load_valid && load_ready)
//   line_out    NRZI-encoded serial line
//   eop_out     high during the SE0 portion of EOP
//   busy        high in every state except IDLE
//   done        one-clk pulse when the packet has completed
//   tx_error    one-clk pulse on underrun
module usb_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int LSB_FIRST  = 1,
    parameter int STUFF_LEN  = 6,
    parameter int EOP_BITS   = 2,
    parameter int IDLE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              bit_strobe,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              line_out,
    output logic              eop_out,
    output logic              busy,
    output logic              done,
    output logic              tx_error
);

    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam int EOP_W  = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);
    localparam logic [EOP_W-1:0]  EOP_LAST  = EOP_W'(EOP_BITS - 1);
    localparam logic              IDLE_BIT  = 1'(IDLE_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_STUFF,
        S_EOP,
        S_JBIT
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_last_q, hold_last_d;
    logic                hold_full_q, hold_full_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [EOP_W-1:0]    eop_cnt_q, eop_cnt_d;
    logic                end_q, end_d;      // packet ends once pending stuff bit is sent
    logic                line_q, line_d;
    logic                eop_q, eop_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic                cur_bit;
    logic                final_bit;
    logic                pkt_ending;
    logic [ONES_W-1:0]   ones_next;
    logic [DATA_W-1:0]   shift_adv;

    assign accept     = load_valid && ready_q;
    assign cur_bit    = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_W-1];
    assign shift_adv  = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
    assign final_bit  = (bit_cnt_q == BIT_LAST);
    // Word is the packet's last either by flag or because nothing follows it.
    assign pkt_ending = last_q || !hold_full_q;
    assign ones_next  = cur_bit ? ones_q + 1'b1 : '0;

    // State register: every register of the block lives here.
    // NOTE: sequential state uses non-blocking (<=) so all registers update
    // together from pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            last_q      <= 1'b0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            ones_q      <= '0;
            eop_cnt_q   <= '0;
            end_q       <= 1'b0;
            line_q      <= IDLE_BIT;
            eop_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_q      <= ones_d;
            eop_cnt_q   <= eop_cnt_d;
            end_q       <= end_d;
            line_q      <= line_d;
            eop_q       <= eop_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hold_full_q || accept) state_d = S_SHIFT;
            S_SHIFT: if (bit_strobe) begin
                         if (ones_next == STUFF_MAX)       state_d = S_STUFF;
                         else if (final_bit && pkt_ending) state_d = S_EOP;
                     end
            S_STUFF: if (bit_strobe) state_d = end_q ? S_EOP : S_SHIFT;
            S_EOP:   if (bit_strobe && eop_cnt_q == EOP_LAST) state_d = S_JBIT;
            S_JBIT:  if (bit_strobe) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        shift_d     = shift_q;
        last_d      = last_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        eop_cnt_d   = eop_cnt_q;
        end_d       = end_q;
        line_d      = line_q;
        eop_d       = eop_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (state_q == S_IDLE) begin
            // A word parked during EOP/J starts the next packet; otherwise an
            // accepted word bypasses the holding register.
            if (hold_full_q) begin
                shift_d     = hold_q;
                last_d      = hold_last_q;
                hold_full_d = 1'b0;
            end else if (accept) begin
                shift_d = load_data;
                last_d  = load_last;
            end
            bit_cnt_d = '0;
            ones_d    = '0;
            eop_cnt_d = '0;
            end_d     = 1'b0;
        end else if (accept) begin
            hold_d      = load_data;
            hold_last_d = load_last;
            hold_full_d = 1'b1;
        end

        if (bit_strobe) begin
            case (state_q)
                S_SHIFT: begin
                    line_d    = cur_bit ? line_q : ~line_q;
                    ones_d    = ones_next;
                    shift_d   = shift_adv;
                    bit_cnt_d = final_bit ? '0 : bit_cnt_q + 1'b1;
                    if (final_bit) begin
                        if (pkt_ending) begin
                            end_d = 1'b1;
                            err_d = !last_q;
                        end else begin
                            // Seamless hand-off; a same-clk accept refills hold.
                            shift_d     = hold_q;
                            last_d      = hold_last_q;
                            hold_full_d = accept;
                        end
                    end
                end
                S_STUFF: begin
                    line_d = ~line_q;
                    ones_d = '0;
                end
                S_EOP: begin
                    eop_d     = 1'b1;
                    eop_cnt_d = (eop_cnt_q == EOP_LAST) ? '0 : eop_cnt_q + 1'b1;
                end
                S_JBIT: begin
                    eop_d  = 1'b0;
                    line_d = IDLE_BIT;
                    done_d = 1'b1;
                    end_d  = 1'b0;
                end
                default: ;
            endcase
        end

        busy_d  = (state_d != S_IDLE);
        ready_d = !hold_full_d;
    end

    assign load_ready = ready_q;
    assign line_out   = line_q;
    assign eop_out    = eop_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tx_error   = err_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer (default parameters).
// Every strobe that the DUT sees while busy yields one observed record
// {line_out, eop_out, done, tx_error, busy}; a packet-level model built from
// the NRZI / stuffing / EOP rules predicts the same record stream.
module tb_usb_tx_serializer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic       line_out;
    logic       eop_out;
    logic       busy;
    logic       done;
    logic       tx_error;

    int         vectors = 0;
    int         miscompares = 0;
    int         strobe_div = 3;
    logic       strobe_stop = 1'b0;
    int         div_cnt = 0;
    logic       strobe_busy = 1'b0;

    logic [4:0] got_q[$];
    logic [4:0] exp_q[$];
    logic [7:0] words[8];

    usb_tx_serializer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bit_strobe (bit_strobe),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .line_out   (line_out),
        .eop_out    (eop_out),
        .busy       (busy),
        .done       (done),
        .tx_error   (tx_error)
    );

    always #5 clk = ~clk;

    // Strobe generator and recorder, both on the falling edge.
    always @(negedge clk) begin
        if (bit_strobe && strobe_busy)
            got_q.push_back({line_out, eop_out, done, tx_error, busy});
        if (strobe_stop) begin
            bit_strobe = 1'b0;
        end else if (div_cnt >= strobe_div - 1) begin
            bit_strobe = 1'b1;
            div_cnt = 0;
        end else begin
            bit_strobe = 1'b0;
            div_cnt++;
        end
        strobe_busy = busy;
    end

    // Expected record stream for words[0..n-1], LSB first, line idles at 1.
    task automatic build_model(input int n, input bit underrun);
        logic line = 1'b1;
        int   ones = 0;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                logic b = words[k][i];
                logic e = underrun && (k == n - 1) && (i == 7);
                if (b) ones++;
                else begin line = ~line; ones = 0; end
                exp_q.push_back({line, 1'b0, 1'b0, e, 1'b1});
                if (ones == 6) begin
                    line = ~line;
                    ones = 0;
                    exp_q.push_back({line, 1'b0, 1'b0, 1'b0, 1'b1});
                end
            end
        end
        for (int j = 0; j < 2; j++) exp_q.push_back({line, 1'b1, 1'b0, 1'b0, 1'b1});
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        load_data  = d;
        load_last  = l;
        load_valid = 1'b1;
        while (load_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout load_ready=%b required=1", load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic feed(input int n, input bit underrun);
        for (int k = 0; k < n; k++) send(words[k], (k == n - 1) && !underrun);
    endtask

    task automatic check_packet(input string name, input int start);
        int t = 0;
        while (got_q.size() < start + exp_q.size() && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout records=%0d required=%0d", name,
                     got_q.size() - start, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [4:0] g;
            g = (start + i < got_q.size()) ? got_q[start + i] : 5'bxxxxx;
            vectors++;
            if (g !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s strobe %0d {line,eop,done,err,busy} got=%b required=%b",
                         name, i, g, exp_q[i]);
            end
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        expect_bit("reset_line",  line_out,   1'b1);
        expect_bit("reset_eop",   eop_out,    1'b0);
        expect_bit("reset_busy",  busy,       1'b0);
        expect_bit("reset_ready", load_ready, 1'b1);
        expect_bit("reset_done",  done,       1'b0);
        expect_bit("reset_err",   tx_error,   1'b0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single(input string name, input logic [7:0] d);
        int start = got_q.size();
        words[0] = d;
        build_model(1, 1'b0);
        feed(1, 1'b0);
        check_packet(name, start);
    endtask

    task automatic test_back_to_back();
        int start = got_q.size();
        words[0] = 8'hFF;
        words[1] = 8'hFF;
        build_model(2, 1'b0);
        send(words[0], 1'b0);
        send(words[1], 1'b1);
        expect_bit("b2b_ready_low", load_ready, 1'b0);
        check_packet("b2b", start);
    endtask

    task automatic test_underrun();
        int start = got_q.size();
        words[0] = 8'h3F;
        build_model(1, 1'b1);
        feed(1, 1'b1);
        check_packet("underrun", start);
    endtask

    task automatic test_reset_midword();
        int t = 0;
        int start = got_q.size();
        send(8'hA5, 1'b1);
        while (got_q.size() < start + 4 && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_rst = 1'b0;
        @(negedge clk);
        expect_bit("midrst_line",  line_out,   1'b1);
        expect_bit("midrst_busy",  busy,       1'b0);
        expect_bit("midrst_ready", load_ready, 1'b1);
        expect_bit("midrst_eop",   eop_out,    1'b0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        test_single("after_reset", 8'h00);
    endtask

    task automatic test_freeze();
        int   t = 0;
        int   start = got_q.size();
        int   sz;
        logic snap;
        words[0] = 8'h96;
        build_model(1, 1'b0);
        feed(1, 1'b0);
        while (got_q.size() < start + 3 && t < 500) begin
            @(negedge clk);
            t++;
        end
        strobe_stop = 1'b1;
        repeat (2) @(negedge clk);
        snap = line_out;
        sz = got_q.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_bit("freeze_line", line_out, snap);
        end
        vectors++;
        if (got_q.size() != sz) begin
            miscompares++;
            $display("FAIL freeze_strobes got=%0d required=%0d", got_q.size(), sz);
        end
        strobe_stop = 1'b0;
        check_packet("freeze", start);
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            int start;
            int n = $urandom_range(1, 3);
            bit ur = ($urandom_range(0, 3) == 0);
            strobe_div = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 2))
                    0:       words[k] = 8'hFF;
                    1:       words[k] = 8'hFF ^ (8'h01 << $urandom_range(0, 7));
                    default: words[k] = 8'($urandom);
                endcase
            end
            start = got_q.size();
            build_model(n, ur);
            feed(n, ur);
            check_packet("random", start);
            repeat (3) @(negedge clk);
        end
        strobe_div = 3;
    endtask

    initial begin
        test_reset();
        test_single("zero_byte", 8'h00);
        test_single("ones_byte", 8'hFF);
        test_back_to_back();
        test_underrun();
        test_reset_midword();
        test_freeze();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
